// File: rtl/ans_table_loader.sv
// Loads a per-symbol frequency table from a count stream, builds the inclusive
// cumulative table serially, and hands it to the ANS decoder once the total is non-zero.
module ans_table_loader #(
  parameter int SYM_WIDTH = 4,
  parameter int CNT_WIDTH = 4,
  parameter int SYM_COUNT = 16
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       load_req,
  input  logic [CNT_WIDTH-1:0]                       in,
  input  logic                                       in_vld,
  output logic                                       in_rdy,
  input  logic                                       dec_idle,
  output logic [CNT_WIDTH*SYM_COUNT-1:0]             counts_unpacked,
  output logic [(CNT_WIDTH+SYM_WIDTH)*SYM_COUNT-1:0] cumulative_unpacked,
  output logic                                       table_vld,
  output logic                                       dec_en,
  output logic                                       busy,
  output logic                                       err_zero
);

  localparam int CW = CNT_WIDTH + SYM_WIDTH;
  localparam int IW = (SYM_COUNT > 1) ? $clog2(SYM_COUNT) : 1;
  localparam logic [IW-1:0] LAST = IW'(SYM_COUNT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, ACCUM, CHECK, READY} state_t;

  state_t               state_q;
  logic [IW-1:0]        idx_q;
  logic [CW-1:0]        acc_q;
  logic [CNT_WIDTH-1:0] counts_q [SYM_COUNT];
  logic [CW-1:0]        cum_q    [SYM_COUNT];
  logic                 in_rdy_q;
  logic                 table_vld_q;
  logic                 dec_en_q;
  logic                 busy_q;
  logic                 err_zero_q;
  logic [CW-1:0]        sum_d;

  assign sum_d = acc_q + CW'(counts_q[idx_q]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      in_rdy_q    <= 1'b0;
      table_vld_q <= 1'b0;
      dec_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      err_zero_q  <= 1'b0;
      for (int unsigned j = 0; j < SYM_COUNT; j++) begin
        counts_q[j] <= '0;
        cum_q[j]    <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (load_req) begin
            state_q    <= LOAD;
            idx_q      <= '0;
            err_zero_q <= 1'b0;
            in_rdy_q   <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        LOAD: begin
          if (in_vld && in_rdy_q) begin
            counts_q[idx_q] <= in;
            if (idx_q == LAST) begin
              state_q  <= ACCUM;
              in_rdy_q <= 1'b0;
              idx_q    <= '0;
              acc_q    <= '0;
            end else begin
              idx_q <= idx_q + IW'(1);
            end
          end
        end
        ACCUM: begin
          cum_q[idx_q] <= sum_d;
          acc_q        <= sum_d;
          if (idx_q == LAST) begin
            state_q <= CHECK;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        CHECK: begin
          busy_q <= 1'b0;
          if (cum_q[LAST] != '0) begin
            state_q     <= READY;
            table_vld_q <= 1'b1;
            dec_en_q    <= 1'b1;
          end else begin
            state_q    <= IDLE;
            err_zero_q <= 1'b1;
          end
        end
        READY: begin
          // Reload waits for the decoder to drain; the requester keeps load_req high.
          if (load_req && dec_idle) begin
            state_q     <= LOAD;
            idx_q       <= '0;
            table_vld_q <= 1'b0;
            dec_en_q    <= 1'b0;
            in_rdy_q    <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < SYM_COUNT; g++) begin : g_pack
    assign counts_unpacked[g*CNT_WIDTH +: CNT_WIDTH] = counts_q[g];
    assign cumulative_unpacked[g*CW +: CW]           = cum_q[g];
  end

  assign in_rdy    = in_rdy_q;
  assign table_vld = table_vld_q;
  assign dec_en    = dec_en_q;
  assign busy      = busy_q;
  assign err_zero  = err_zero_q;

endmodule

// File: doc/ans_table_loader.md
ANS_TABLE_LOADER -- requirements
Module: ans_table_loader

Interface
REQ-001 SHALL have parameter SYM_WIDTH, default 4, symbol width in bits.
REQ-002 SHALL have parameter CNT_WIDTH, default 4, per-symbol count width; CW = CNT_WIDTH+SYM_WIDTH is the cumulative entry width.
REQ-003 SHALL have parameter SYM_COUNT, default 16, number of symbols; SYM_COUNT <= 2**SYM_WIDTH.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port load_req  input  1  level request to (re)load the frequency table.
REQ-007 SHALL have ports in / in_vld / in_rdy  input / input / output  CNT_WIDTH / 1 / 1  count stream, symbol 0 first.
REQ-008 SHALL have port dec_idle  input  1  decoder reports no symbol in flight.
REQ-009 SHALL have port counts_unpacked  output  CNT_WIDTH*SYM_COUNT  count j at bits [j*CNT_WIDTH +: CNT_WIDTH].
REQ-010 SHALL have port cumulative_unpacked  output  CW*SYM_COUNT  inclusive prefix sum j at bits [j*CW +: CW].
REQ-011 SHALL have ports table_vld / dec_en / busy / err_zero  output  1 each  table usable / decoder enable / load in progress / zero-total error.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, ACCUM, CHECK, READY; all outputs registered.
REQ-013 IDLE: load_req=1 -> LOAD, beat index cleared, err_zero cleared, in_rdy set on the same edge.
REQ-014 LOAD: beat accepted only when in_vld && in_rdy; counts[idx] <= in, idx increments; in_vld gaps stall with no state change.
REQ-015 LOAD: on acceptance of beat SYM_COUNT-1, in_rdy clears on that edge -> ACCUM; in_rdy is 0 in every other state.
REQ-016 ACCUM: one entry per cycle, k = 0..SYM_COUNT-1: cum[k] <= acc + counts[k], acc <= acc + counts[k]; acc cleared on ACCUM entry; after k = SYM_COUNT-1 -> CHECK.
REQ-017 Sum SHALL be computed in CW bits; no overflow is possible under REQ-003, no saturation logic.
REQ-018 CHECK: cum[SYM_COUNT-1] != 0 -> READY with table_vld=1, dec_en=1; == 0 -> IDLE with err_zero=1 (sticky until next accepted load_req).
REQ-019 Latency: table_vld rises exactly SYM_COUNT+1 cycles after the edge accepting the last beat.
REQ-020 busy SHALL be 1 in LOAD, ACCUM, CHECK; 0 in IDLE, READY.
REQ-021 READY: load_req=1 && dec_idle=1 -> LOAD; table_vld, dec_en clear on that same edge; load_req with dec_idle=0 ignored that cycle (requester holds level).
REQ-022 counts_unpacked/cumulative_unpacked SHALL hold last values outside LOAD/ACCUM; contents are undefined for consumers while table_vld=0.
REQ-023 load_req in LOAD, ACCUM, CHECK SHALL be ignored; no abort path other than rst.
REQ-024 dec_en SHALL never be 1 while table_vld=0.

Reset
REQ-025 rst=1 SHALL immediately force IDLE, in_rdy=0, table_vld=0, dec_en=0, busy=0, err_zero=0, all counts and cumulative entries 0, indices and acc 0, from any state including mid-LOAD/ACCUM.
REQ-026 After rst release, first load_req sampled on the next rising edge; no partial table retained.

Verification
REQ-027 Reset, load_req=1, 16 beats of 1 back-to-back -> cum[j]=j+1, cum[15]=16, table_vld=1 17 cycles after last beat, dec_en=1, busy=0.
REQ-028 Counts 15,0,0,...,0,1 with in_vld low every other cycle -> every beat accepted only when in_vld=1, cum[0..14]=15, cum[15]=16, no lost/duplicated beat.
REQ-029 All 16 counts 0 -> FSM returns IDLE, err_zero=1, table_vld=0, dec_en=0; next load with counts 2 clears err_zero at load start, cum[15]=32.
REQ-030 READY, load_req=1, dec_idle=0 for 5 cycles then 1 -> table_vld stays 1 five cycles, drops same edge as LOAD entry, in_rdy=1.
REQ-031 rst pulsed after 7 of 16 beats -> all outputs zero immediately; fresh full load of 16 counts of 15 -> cum[15]=240, table_vld=1.
REQ-032 load_req toggled during ACCUM -> no effect on sequence or latency of REQ-019.
